// File: rtl/cw310_reg_host_bridge_if.sv
// Signal bundle between the host byte streams, the bridge, and the CW310 register responders.
// The master modport is the bridge side; the slave modport is the host/responder side.
interface cw310_reg_host_bridge_if #(
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pBYTECNT_SIZE = 7
);
  logic [7:0]                           rx_data;
  logic                                 rx_valid;
  logic                                 rx_ready;
  logic [7:0]                           tx_data;
  logic                                 tx_valid;
  logic                                 tx_ready;
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
  logic [7:0]                           write_data;
  logic [7:0]                           read_data;
  logic                                 reg_addrvalid;
  logic                                 reg_write;
  logic                                 reg_read;
  logic                                 busy;
  logic                                 timeout_err;
  logic                                 clear_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, read_data, clear_err,
    output rx_ready, tx_data, tx_valid, reg_address, reg_bytecnt, write_data,
    output reg_addrvalid, reg_write, reg_read, busy, timeout_err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, read_data, clear_err,
    input  rx_ready, tx_data, tx_valid, reg_address, reg_bytecnt, write_data,
    input  reg_addrvalid, reg_write, reg_read, busy, timeout_err
  );
endinterface

// File: rtl/cw310_reg_host_bridge.sv
// Host byte stream to CW310 register bus initiator: CMD, ADDR_LO, ADDR_HI, [data...] packets
// become write strobes or read requests whose results stream back on tx.
module cw310_reg_host_bridge #(
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter int unsigned pTIMEOUT      = 65535
) (
  input logic                     usb_clk,
  input logic                     reset_n,
  cw310_reg_host_bridge_if.master bus
);

  localparam int unsigned AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int unsigned BW = pBYTECNT_SIZE;
  localparam int unsigned TW = $clog2(pTIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddrLo,
    StAddrHi,
    StWrData,
    StWrStrobe,
    StRdReq,
    StRdCap,
    StRdSend
  } state_e;

  state_e state_q, state_d;

  logic          wr_q, wr_d;
  logic [6:0]    len_q, len_d;
  logic [6:0]    idx_q, idx_d;
  logic [7:0]    addr_lo_q, addr_lo_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [AW-1:0] reg_address_q, reg_address_d;
  logic [BW-1:0] reg_bytecnt_q, reg_bytecnt_d;
  logic [7:0]    write_data_q, write_data_d;
  logic          reg_addrvalid_q, reg_addrvalid_d;
  logic          reg_write_q, reg_write_d;
  logic          reg_read_q, reg_read_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;

  logic rx_ready;
  logic rx_fire;
  logic tx_fire;
  logic counting;
  logic tmo_hit;

  always_comb begin
    rx_ready = (state_q == StIdle) || (state_q == StAddrLo) ||
               (state_q == StAddrHi) || (state_q == StWrData);
    rx_fire  = rx_ready & bus.rx_valid;
    tx_fire  = (state_q == StRdSend) & bus.tx_ready;
    counting = (state_q == StAddrLo) || (state_q == StAddrHi) || (state_q == StWrData);
  end

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    len_d         = len_q;
    idx_d         = idx_q;
    addr_lo_d     = addr_lo_q;
    reg_address_d = reg_address_q;
    write_data_d  = write_data_q;
    tx_data_d     = tx_data_q;
    tmo_cnt_d     = '0;
    tmo_hit       = 1'b0;

    // Idle gap counter; any accepted byte or non-counting state keeps it at zero.
    if (counting && !rx_fire) begin
      if (tmo_cnt_q == TW'(pTIMEOUT - 1)) begin
        tmo_hit = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          wr_d    = bus.rx_data[7];
          len_d   = bus.rx_data[6:0];
          state_d = StAddrLo;
        end
      end
      StAddrLo: begin
        if (rx_fire) begin
          addr_lo_d = bus.rx_data;
          state_d   = StAddrHi;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StAddrHi: begin
        if (rx_fire) begin
          // Upper address bits beyond the bus width are dropped.
          reg_address_d = AW'({bus.rx_data, addr_lo_q});
          idx_d         = '0;
          state_d       = wr_q ? StWrData : StRdReq;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StWrData: begin
        if (rx_fire) begin
          write_data_d = bus.rx_data;
          state_d      = StWrStrobe;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StWrStrobe: begin
        if (idx_q == len_q) begin
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StWrData;
        end
      end
      StRdReq: begin
        state_d = StRdCap;
      end
      StRdCap: begin
        tx_data_d = bus.read_data;
        state_d   = StRdSend;
      end
      StRdSend: begin
        if (tx_fire) begin
          if (idx_q == len_q) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRdReq;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Strobes are registered, so they are decoded from the state being entered.
    reg_write_d     = (state_d == StWrStrobe);
    reg_read_d      = (state_d == StRdReq) || (state_d == StRdCap);
    reg_addrvalid_d = reg_write_d || reg_read_d;
    tx_valid_d      = (state_d == StRdSend);
    busy_d          = (state_d != StIdle);
    reg_bytecnt_d   = BW'(idx_d);

    if (tmo_hit) begin
      timeout_err_d = 1'b1;
    end else if (bus.clear_err) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      wr_q            <= 1'b0;
      len_q           <= '0;
      idx_q           <= '0;
      addr_lo_q       <= '0;
      tmo_cnt_q       <= '0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      reg_address_q   <= '0;
      reg_bytecnt_q   <= '0;
      write_data_q    <= '0;
      reg_addrvalid_q <= 1'b0;
      reg_write_q     <= 1'b0;
      reg_read_q      <= 1'b0;
      busy_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_q            <= wr_d;
      len_q           <= len_d;
      idx_q           <= idx_d;
      addr_lo_q       <= addr_lo_d;
      tmo_cnt_q       <= tmo_cnt_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      reg_address_q   <= reg_address_d;
      reg_bytecnt_q   <= reg_bytecnt_d;
      write_data_q    <= write_data_d;
      reg_addrvalid_q <= reg_addrvalid_d;
      reg_write_q     <= reg_write_d;
      reg_read_q      <= reg_read_d;
      busy_q          <= busy_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign bus.rx_ready      = rx_ready;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.reg_address   = reg_address_q;
  assign bus.reg_bytecnt   = reg_bytecnt_q;
  assign bus.write_data    = write_data_q;
  assign bus.reg_addrvalid = reg_addrvalid_q;
  assign bus.reg_write     = reg_write_q;
  assign bus.reg_read      = reg_read_q;
  assign bus.busy          = busy_q;
  assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_cw310_reg_host_bridge.sv
// Randomized packet-level bench for cw310_reg_host_bridge; expected register traffic and
// read-back bytes come from the packet contents and a fixed responder function.
module tb_cw310_reg_host_bridge;

  localparam int unsigned AW = 14;
  localparam int unsigned BW = 7;

  logic usb_clk = 1'b0;
  logic reset_n = 1'b1;

  cw310_reg_host_bridge_if #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) bus_if ();

  cw310_reg_host_bridge #(
    .pADDR_WIDTH  (21),
    .pBYTECNT_SIZE(7),
    .pTIMEOUT     (16)
  ) u_dut (
    .usb_clk(usb_clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  always #5 usb_clk = ~usb_clk;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  logic [AW+BW+7:0] obs_wr[$];
  logic [AW+BW+7:0] exp_wr[$];
  logic [7:0] pdat[128];

  function automatic logic [7:0] rd_fn(input logic [AW-1:0] a, input logic [BW-1:0] bc);
    return 8'h40 + {1'b0, bc} + a[13:6];
  endfunction

  // Responder: combinational read data derived from the presented address.
  assign bus_if.read_data = rd_fn(bus_if.reg_address, bus_if.reg_bytecnt);

  always @(negedge usb_clk) begin
    if (reset_n) begin
      if (bus_if.reg_write) obs_wr.push_back({bus_if.reg_address, bus_if.reg_bytecnt,
                                              bus_if.write_data});
      if (bus_if.reg_read) rd_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    bus_if.rx_valid = 1'b0;
    repeat (gap) step();
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    w = 0;
    while (!bus_if.rx_ready && w < 50) begin
      step();
      w++;
    end
    if (w != 0) check_eq("rx_ready_wait", bus_if.rx_ready, 1);
    step();
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, input int hold);
    int w;
    logic [7:0] v;
    logic unstable;
    w = 0;
    while (!bus_if.tx_valid && w < 50) begin
      step();
      w++;
    end
    check_eq("tx_valid_wait", bus_if.tx_valid, 1);
    v = bus_if.tx_data;
    unstable = 1'b0;
    repeat (hold) begin
      step();
      if (bus_if.tx_data !== v || !bus_if.tx_valid) unstable = 1'b1;
    end
    if (hold > 0) check_eq("tx_stable", unstable, 0);
    bus_if.tx_ready = 1'b1;
    b = bus_if.tx_data;
    step();
    bus_if.tx_ready = 1'b0;
  endtask

  // Sends one packet with data from pdat[] and checks every resulting bus effect.
  task automatic run_pkt(input logic [7:0] cmd, input logic [15:0] addr, input int hold0);
    int len;
    int rd0;
    int w;
    logic [AW-1:0] ea;
    logic [7:0] b;
    len = int'(cmd[6:0]) + 1;
    ea  = addr[AW-1:0];
    rd0 = rd_cnt;
    obs_wr.delete();
    exp_wr.delete();
    send_byte(cmd, $urandom_range(0, 3));
    send_byte(addr[7:0], $urandom_range(0, 3));
    send_byte(addr[15:8], $urandom_range(0, 3));
    if (cmd[7]) begin
      for (int i = 0; i < len; i++) begin
        exp_wr.push_back({ea, BW'(i), pdat[i]});
        send_byte(pdat[i], $urandom_range(0, 3));
        check_eq("wr_strobe_lat", bus_if.reg_write, 1);
        check_eq("wr_rx_blocked", bus_if.rx_ready, 0);
        check_eq("wr_addr", bus_if.reg_address, ea);
      end
    end else begin
      for (int i = 0; i < len; i++) begin
        recv_byte(b, (i == 0) ? hold0 : $urandom_range(0, 3));
        check_eq("rd_byte", b, rd_fn(ea, BW'(i)));
      end
    end
    w = 0;
    while (bus_if.busy && w < 10) begin
      step();
      w++;
    end
    check_eq("busy_fall", bus_if.busy, 0);
    if (cmd[7]) begin
      check_eq("wr_count", obs_wr.size(), exp_wr.size());
      foreach (exp_wr[i]) begin
        if (i < obs_wr.size()) check_eq("wr_beat", obs_wr[i], exp_wr[i]);
      end
    end else begin
      check_eq("rd_strobe_cycles", rd_cnt - rd0, 2 * len);
      check_eq("rd_no_writes", obs_wr.size(), 0);
    end
  endtask

  initial begin
    bus_if.rx_data   = '0;
    bus_if.rx_valid  = 1'b0;
    bus_if.tx_ready  = 1'b0;
    bus_if.clear_err = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge usb_clk);
    #1;
    check_eq("rst_tx_valid", bus_if.tx_valid, 0);
    check_eq("rst_busy", bus_if.busy, 0);
    check_eq("rst_strobes", {bus_if.reg_write, bus_if.reg_read, bus_if.reg_addrvalid}, 0);
    check_eq("rst_err", bus_if.timeout_err, 0);
    check_eq("rst_regs", {bus_if.tx_data, bus_if.write_data, bus_if.reg_address,
                          bus_if.reg_bytecnt}, 0);
    reset_n = 1'b1;
    step();
    check_eq("rst_rx_ready", bus_if.rx_ready, 1);

    // Directed write: four bytes to 0x0005.
    pdat[0] = 8'h11; pdat[1] = 8'h22; pdat[2] = 8'h33; pdat[3] = 8'h44;
    run_pkt(8'h83, 16'h0005, 0);
    check_eq("dir_wr_last", obs_wr.size() > 3 ? obs_wr[3] : 0, {14'h0005, 7'd3, 8'h44});

    // Directed read: two bytes from 0x000A -> 0x40, 0x41.
    run_pkt(8'h01, 16'h000A, 0);

    // Backpressure: first byte held for 1000 cycles.
    run_pkt(8'h02, 16'h0123, 1000);
    check_eq("bp_no_timeout", bus_if.timeout_err, 0);

    // Address truncation.
    pdat[0] = 8'h5A;
    run_pkt(8'h80, 16'hFF34, 0);
    check_eq("addr_trunc", bus_if.reg_address, 14'h3F34);

    // Timeout after CMD + ADDR_LO.
    obs_wr.delete();
    send_byte(8'h80, 0);
    send_byte(8'h01, 0);
    repeat (15) step();
    check_eq("tmo_not_yet", bus_if.timeout_err, 0);
    check_eq("tmo_busy_before", bus_if.busy, 1);
    step();
    check_eq("tmo_err_set", bus_if.timeout_err, 1);
    check_eq("tmo_idle", bus_if.busy, 0);
    repeat (3) step();
    check_eq("tmo_no_write", obs_wr.size(), 0);
    pdat[0] = 8'hC3; pdat[1] = 8'h3C;
    run_pkt(8'h81, 16'h0200, 0);
    check_eq("tmo_err_sticky", bus_if.timeout_err, 1);
    bus_if.clear_err = 1'b1;
    step();
    bus_if.clear_err = 1'b0;
    check_eq("tmo_err_clear", bus_if.timeout_err, 0);

    // Reset after two of four data bytes.
    obs_wr.delete();
    send_byte(8'h83, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    step();
    check_eq("mid_two_writes", obs_wr.size(), 2);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_outs", {bus_if.tx_valid, bus_if.busy, bus_if.reg_write, bus_if.reg_read,
                              bus_if.reg_addrvalid, bus_if.timeout_err}, 0);
    check_eq("mid_rst_regs", {bus_if.tx_data, bus_if.write_data, bus_if.reg_address,
                              bus_if.reg_bytecnt}, 0);
    step();
    reset_n = 1'b1;
    step();
    // 0x33 is now a read command of 52 bytes, 0x44 its ADDR_LO.
    run_pkt(8'h33, 16'h0044, 0);

    // Randomized packets.
    for (int p = 0; p < 40; p++) begin
      logic [7:0] cmd;
      logic [15:0] addr;
      int len;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 128) : $urandom_range(1, 8);
      cmd = {1'($urandom_range(0, 1)), 7'(len - 1)};
      addr = 16'($urandom);
      for (int i = 0; i < 128; i++) pdat[i] = 8'($urandom);
      run_pkt(cmd, addr, $urandom_range(0, 5));
    end
    check_eq("end_no_err", bus_if.timeout_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cw310_reg_host_bridge.md
# cw310_reg_host_bridge

Initiator for the CW310 register bus: converts a host byte stream (valid/ready, e.g. from a UART or FTDI FIFO core) into register-bus transactions on the same bus the CW310 register-block responders consume. It drives address, byte count, write strobes and read strobes, and returns read bytes on a transmit byte stream. Single clock domain (`usb_clk`); it sits between the host-link PHY and the register responders.

## Interface
Parameters:
- `pADDR_WIDTH`, 21: total bus address width.
- `pBYTECNT_SIZE`, 7: byte-count width; address field is `pADDR_WIDTH-pBYTECNT_SIZE` (14) bits.
- `pTIMEOUT`, 65535: max idle `usb_clk` cycles between bytes of one packet before abort.

Ports:
- `usb_clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: host command/data byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: bridge accepts byte; transfer when `rx_valid & rx_ready`.
- `tx_data` out 8: read-back byte to host.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: host accepts byte.
- `reg_address` out `pADDR_WIDTH-pBYTECNT_SIZE`: register address.
- `reg_bytecnt` out `pBYTECNT_SIZE`: byte index in register.
- `write_data` out 8: write byte.
- `read_data` in 8: responder read byte (combinational from responder).
- `reg_addrvalid` out 1: address/bytecnt valid.
- `reg_write` out 1: one-cycle write strobe.
- `reg_read` out 1: read strobe.
- `busy` out 1: high in any state except IDLE.
- `timeout_err` out 1: sticky; set on packet timeout.
- `clear_err` in 1: synchronous clear of `timeout_err`.

## Operation
- Packet: CMD, ADDR_LO, ADDR_HI, then data (writes only). CMD[7]=1 write / 0 read; CMD[6:0]=LEN-1 (LEN 1..128). Address = {ADDR_HI,ADDR_LO} truncated to address width (upper bits ignored). Byte index i runs 0..LEN-1 and drives `reg_bytecnt`; LEN > 2^`pBYTECNT_SIZE` is impossible at default; for smaller `pBYTECNT_SIZE`, index wraps modulo 2^`pBYTECNT_SIZE`.
- States: IDLE, ADDR_LO, ADDR_HI, WR_DATA, WR_STROBE, RD_REQ, RD_CAP, RD_SEND.
- IDLE: `rx_ready`=1; accepted byte latched as CMD -> ADDR_LO.
- ADDR_LO/ADDR_HI: `rx_ready`=1; accept byte -> next; after ADDR_HI go WR_DATA (write) or RD_REQ (read), i=0.
- WR_DATA: `rx_ready`=1; accepted byte latched to `write_data` -> WR_STROBE.
- WR_STROBE: `reg_addrvalid`=1, `reg_write`=1, `reg_bytecnt`=i, `rx_ready`=0. Then i==LEN-1 -> IDLE, else i+1 -> WR_DATA.
- RD_REQ: `reg_addrvalid`=1, `reg_read`=1 -> RD_CAP.
- RD_CAP: strobes held; `read_data` captured into `tx_data` at end of cycle -> RD_SEND.
- RD_SEND: strobes low, `tx_valid`=1, `tx_data` stable until `tx_ready`; on handshake i==LEN-1 -> IDLE, else i+1 -> RD_REQ.
- `rx_ready`=0 in all read states; `tx_valid`=0 outside RD_SEND.
- Timeout: counter resets on every accepted byte and on entering ADDR_LO; counts only in ADDR_LO, ADDR_HI, WR_DATA. Reaching `pTIMEOUT` -> IDLE, `timeout_err`=1, no strobe for the pending byte. RD_SEND never times out (host backpressure unbounded).
- `timeout_err` set and `clear_err` same cycle: set wins.
- All outputs registered except `rx_ready`, decoded from state.

## Timing
- Reset (async assert, sync-released by top): state IDLE; `tx_valid`, `reg_write`, `reg_read`, `reg_addrvalid`, `busy`, `timeout_err` = 0; `tx_data`, `write_data`, `reg_address`, `reg_bytecnt` = 0; `rx_ready`=1 from first clock after release.
- Reset mid-packet: packet discarded, no strobe issued afterwards.
- Write latency: data byte accepted cycle N -> `reg_write` high exactly cycle N+1; next byte acceptable cycle N+2. Max throughput 1 write per 2 cycles.
- Read: RD_REQ at cycle M, capture at end of M+1, `tx_valid` from M+2. Min 3 cycles per read byte.
- `reg_address`/`reg_bytecnt` stable whenever `reg_addrvalid`=1.

## Test plan
- Write: send 0x83,0x05,0x00,0x11,0x22,0x33,0x44 -> four `reg_write` pulses, address 0x0005, bytecnt 0..3, `write_data` 0x11..0x44, each one cycle after byte accept; `busy` falls after last.
- Read: send 0x01,0x0A,0x00 with responder `read_data`=0x40+bytecnt -> `tx_data` 0x40,0x41; `reg_read` two cycles per byte.
- Backpressure: read LEN=3, hold `tx_ready`=0 for 1000 cycles -> `tx_data` stable, no extra `reg_read`, no timeout; release -> bytes in order.
- Timeout: `pTIMEOUT`=16, send 0x80,0x01 then stall -> `timeout_err`=1 after 16 idle cycles, state IDLE, no `reg_write`; next packet works; `clear_err` clears flag.
- Address truncation: ADDR_HI=0xFF, ADDR_LO=0x34 -> `reg_address`=0x3F34.
- Reset mid-write after 2 of 4 data bytes -> outputs at reset values, subsequent bytes treated as new CMD.
